// File: rtl/delta2_seq.sv
// Sequencer that time-multiplexes one shared delta2 datapath over all hidden
// neurons: read operands, load the unit, wait its latency, write the result.
module delta2_seq #(
    parameter int N_HID  = 5,
    parameter int ADDR_W = 3,
    parameter int DP_LAT = 1
) (
    input  logic              clk,
    input  logic              res,
    input  logic              start,
    input  logic [15:0]       delta3_1_in,
    input  logic [15:0]       delta3_2_in,
    output logic              mem_rd_en,
    output logic [ADDR_W-1:0] mem_rd_addr,
    input  logic [15:0]       mem_dadz2,
    input  logic [15:0]       mem_w3_1,
    input  logic [15:0]       mem_w3_2,
    output logic [15:0]       dp_dadz2,
    output logic [15:0]       dp_w3_1,
    output logic [15:0]       dp_w3_2,
    output logic [15:0]       dp_delta3_1,
    output logic [15:0]       dp_delta3_2,
    input  logic [15:0]       dp_result,
    output logic              res_we,
    output logic [ADDR_W-1:0] res_addr,
    output logic [15:0]       res_data,
    output logic              busy,
    output logic              done
);

    localparam int CNT_W = (DP_LAT > 1) ? $clog2(DP_LAT) : 1;
    localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(DP_LAT - 1);
    localparam logic [ADDR_W-1:0] K_LAST   = ADDR_W'(N_HID - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_RD,
        S_LOAD,
        S_WAIT,
        S_WR,
        S_DONE
    } state_t;

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] k_q, k_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [15:0]       dp_dadz2_q, dp_dadz2_d;
    logic [15:0]       dp_w3_1_q, dp_w3_1_d;
    logic [15:0]       dp_w3_2_q, dp_w3_2_d;
    logic [15:0]       dp_delta3_1_q, dp_delta3_1_d;
    logic [15:0]       dp_delta3_2_q, dp_delta3_2_d;

    always_comb begin
        // NOTE: every always_comb target gets a default first so no path leaves it unassigned (no latch).
        state_d       = state_q;
        k_d           = k_q;
        cnt_d         = cnt_q;
        dp_dadz2_d    = dp_dadz2_q;
        dp_w3_1_d     = dp_w3_1_q;
        dp_w3_2_d     = dp_w3_2_q;
        dp_delta3_1_d = dp_delta3_1_q;
        dp_delta3_2_d = dp_delta3_2_q;

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    dp_delta3_1_d = delta3_1_in;
                    dp_delta3_2_d = delta3_2_in;
                    k_d           = '0;
                    state_d       = S_RD;
                end
            end
            S_RD: begin
                state_d = S_LOAD;
            end
            S_LOAD: begin
                // Memory data is valid only in this cycle, one after the read strobe.
                dp_dadz2_d = mem_dadz2;
                dp_w3_1_d  = mem_w3_1;
                dp_w3_2_d  = mem_w3_2;
                cnt_d      = '0;
                state_d    = S_WAIT;
            end
            S_WAIT: begin
                if (cnt_q == CNT_LAST) begin
                    state_d = S_WR;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            S_WR: begin
                if (k_q == K_LAST) begin
                    state_d = S_DONE;
                end else begin
                    k_d     = k_q + ADDR_W'(1);
                    state_d = S_RD;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so all flops update together at the edge.
    always_ff @(posedge clk or posedge res) begin
        if (res) begin
            state_q       <= S_IDLE;
            k_q           <= '0;
            cnt_q         <= '0;
            dp_dadz2_q    <= '0;
            dp_w3_1_q     <= '0;
            dp_w3_2_q     <= '0;
            dp_delta3_1_q <= '0;
            dp_delta3_2_q <= '0;
        end else begin
            state_q       <= state_d;
            k_q           <= k_d;
            cnt_q         <= cnt_d;
            dp_dadz2_q    <= dp_dadz2_d;
            dp_w3_1_q     <= dp_w3_1_d;
            dp_w3_2_q     <= dp_w3_2_d;
            dp_delta3_1_q <= dp_delta3_1_d;
            dp_delta3_2_q <= dp_delta3_2_d;
        end
    end

    always_comb begin
        mem_rd_en   = (state_q == S_RD);
        mem_rd_addr = k_q;
        res_we      = (state_q == S_WR);
        res_addr    = k_q;
        // Pass-through of the unit's result; held at zero outside the write strobe.
        res_data    = (state_q == S_WR) ? dp_result : '0;
        busy        = (state_q != S_IDLE);
        done        = (state_q == S_DONE);
        dp_dadz2    = dp_dadz2_q;
        dp_w3_1     = dp_w3_1_q;
        dp_w3_2     = dp_w3_2_q;
        dp_delta3_1 = dp_delta3_1_q;
        dp_delta3_2 = dp_delta3_2_q;
    end

endmodule

// File: doc/delta2_seq.md
Name: delta2_seq

Overview:
- Sequencer that time-multiplexes one shared delta2 datapath unit over all N_HID hidden neurons of the backprop hidden layer.
- On start, latches the two output-layer deltas, then for each hidden neuron k:
  - reads that neuron's dadz2 and w3 pair from a synchronous operand memory;
  - drives the shared unit's operands;
  - waits the unit's latency;
  - writes delta2_k to a result memory.
- Sits between the delta3 stage and the weight-update stage of the backprop controller.

Parameters:
- N_HID, 5, number of hidden neurons processed per run (>=1).
- ADDR_W, 3, operand/result memory address width (2**ADDR_W >= N_HID).
- DP_LAT, 1, clock latency of the shared delta2 datapath (>=1).

Ports:
- clk  in  1  clock.
- res  in  1  reset, asynchronous, active-high.
- start  in  1  run request, sampled only in IDLE.
- delta3_1_in  in  16  signed Q6.10 delta3 of output neuron 1, captured on start acceptance.
- delta3_2_in  in  16  signed Q6.10 delta3 of output neuron 2, captured on start acceptance.
- mem_rd_en  out  1  operand memory read enable.
- mem_rd_addr  out  ADDR_W  operand address (neuron k).
- mem_dadz2  in  16  signed Q6.10 dadz2_k, valid the cycle after mem_rd_en.
- mem_w3_1  in  16  signed Q6.10 w3_k1, same timing as mem_dadz2.
- mem_w3_2  in  16  signed Q6.10 w3_k2, same timing as mem_dadz2.
- dp_dadz2  out  16  operand to shared unit (registered).
- dp_w3_1  out  16  operand to shared unit (registered).
- dp_w3_2  out  16  operand to shared unit (registered).
- dp_delta3_1  out  16  operand to shared unit (registered).
- dp_delta3_2  out  16  operand to shared unit (registered).
- dp_result  in  16  delta2 from shared unit, valid DP_LAT cycles after operands change.
- res_we  out  1  result memory write strobe.
- res_addr  out  ADDR_W  result address (neuron k).
- res_data  out  16  result data, equals dp_result during res_we.
- busy  out  1  run in progress.
- done  out  1  one-cycle pulse at end of run.

Behaviour:
- Reset (async, res=1): state IDLE, k=0, wait counter 0. All outputs 0, including dp_* regs and the captured delta3 regs. Reset mid-run aborts immediately; the partial result memory contents are undefined, and there is no done pulse.
- States are IDLE, RD, LOAD, WAIT, WR, DONE. Cycle numbering: cycle 1 is the first cycle after the edge that accepts start.
- IDLE:
  - busy=0.
  - start=1 at an edge: capture delta3_1_in/delta3_2_in into dp_delta3_1/dp_delta3_2, set k=0, go to RD.
- RD:
  - mem_rd_en=1, mem_rd_addr=k.
  - Next state LOAD.
- LOAD:
  - mem_* valid this cycle.
  - At the edge, dp_dadz2/dp_w3_1/dp_w3_2 <= mem_dadz2/mem_w3_1/mem_w3_2; wait counter <= 0.
  - Next state WAIT.
- WAIT:
  - Stays exactly DP_LAT cycles; the counter increments each cycle.
  - Next state WR when counter == DP_LAT-1.
- WR:
  - res_we=1, res_addr=k, res_data=dp_result (combinational pass-through, no rounding or saturation; width handling belongs to the datapath).
  - If k==N_HID-1, go to DONE; else k<=k+1 and go to RD.
- DONE:
  - done=1 for this single cycle, busy=1.
  - Next state IDLE.
- Timing per neuron: 3+DP_LAT cycles.
  - Neuron k has RD in cycle (3+DP_LAT)k+1 and WR in cycle (3+DP_LAT)(k+1).
  - DONE is in cycle N_HID(3+DP_LAT)+1.
- busy is 1 in all states except IDLE.
- mem_rd_en and res_we are 0 outside RD and WR respectively. mem_rd_addr and res_addr hold k at all times.
- start is ignored while busy; delta3_*_in changes after acceptance have no effect.
- In DONE, start is ignored. start held high continuously gives back-to-back runs separated by exactly one IDLE cycle.
- dp_* hold their last values after the run until the next LOAD or start.

Test Plan:
- Single-neuron value (N_HID=5, DP_LAT=1, bench datapath model = product bits [35:20] registered 1 cycle):
  - Stimulus: all neurons dadz2=0x0400, w3_1=0x0400, w3_2=0; delta3_1=0x0400, delta3_2=0.
  - Required: every res_data=0x0400, writes at cycles 4,8,12,16,20 to addresses 0..4, done pulse at cycle 21, busy high in cycles 1-21.
- Mixed signs:
  - Stimulus: neuron 2 has w3_1=0xFC00 (-1.0), w3_2=0x0200 (0.5), dadz2=0x0400; delta3_1=0x0400, delta3_2=0x0400.
  - Required: res_addr=2 written with 0xFE00 (-0.5).
- Latency parameter:
  - Stimulus: DP_LAT=3, N_HID=2.
  - Required: WR at cycles 6 and 12, done at cycle 13, dp operands stable through each WAIT.
- start while busy:
  - Stimulus: pulse start at cycle 7 with delta3_1_in changed.
  - Required: ignored; results match the originally captured delta3, exactly one done pulse.
- Async reset mid-run:
  - Stimulus: assert res between clock edges in cycle 9.
  - Required: busy, res_we, mem_rd_en and dp_* go to 0 immediately with no clock edge; no done pulse; a new start after release runs a full sequence from k=0.
- Back-to-back runs:
  - Stimulus: hold start high.
  - Required: second run's first RD occurs 2 cycles after the first run's done (DONE, IDLE, RD).
